// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
//   Shared definitions for the UART TX feeder slice:
//   - default payload width
//   - launch FSM state encodings (as localparams and as a typed enum)
//   - launch condition helper used by the launch FSM
// -----------------------------------------------------------------------------
package uart_tx_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    // Launch FSM encodings are fixed so external debug taps can decode them.
    localparam logic [1:0] LS_IDLE      = 2'b00;
    localparam logic [1:0] LS_ISSUE     = 2'b01;
    localparam logic [1:0] LS_WAIT_BUSY = 2'b10;
    localparam logic [1:0] LS_WAIT_DONE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE      = LS_IDLE,
        ST_ISSUE     = LS_ISSUE,
        ST_WAIT_BUSY = LS_WAIT_BUSY,
        ST_WAIT_DONE = LS_WAIT_DONE
    } launch_state_e;

    // A byte may be launched only when something is queued, the host allows
    // transmission and the frame FSM is free.
    function automatic logic launch_ok(
        input logic fifo_empty,
        input logic tx_enable,
        input logic tx_busy
    );
        return !fifo_empty && tx_enable && !tx_busy;
    endfunction

endpackage : uart_tx_pkg

// File: rtl/tx_sync_fifo.sv
// -----------------------------------------------------------------------------
// tx_sync_fifo
//   Single-clock byte FIFO feeding the UART launch FSM.
//   Ports:
//     clk, rst        clock, asynchronous active-low reset
//     wr_en, wr_data  push request and data (ignored when full -> overflow)
//     rd_en           pop request (ignored when empty)
//     ovf_clr         clears the sticky overflow flag
//     head            entry at the read pointer (valid when !empty)
//     full, empty     registered occupancy flags
//     level           registered occupancy 0..DEPTH
//     overflow        sticky flag: a write was dropped
//   All status outputs are registered and reflect push/pop the next cycle.
// -----------------------------------------------------------------------------
module tx_sync_fifo
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = $clog2(DEPTH)   // derived, leave at default
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  ovf_clr,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_W:0]       level,
    output logic                  overflow
);

    localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q,  level_d;
    logic              full_q,   full_d;
    logic              empty_q,  empty_d;
    logic              ovf_q,    ovf_d;

    logic push;
    logic pop;
    logic drop;

    // Full is judged on the registered flag, so a write arriving while full
    // is dropped even if a pop frees a slot in the same cycle.
    assign push = wr_en && !full_q;
    assign drop = wr_en &&  full_q;
    assign pop  = rd_en && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        // DEPTH is a power of two, so pointer wrap is plain overflow.
        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
            2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
            default: level_d = level_q;
        endcase

        full_d  = (level_d == LEVEL_FULL);
        empty_d = (level_d == '0);

        // A drop in the same cycle as a clear wins, so no loss goes unreported.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage carries no reset; stale contents are unreachable once the
    // pointers are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Head is read combinationally so the launch edge can capture it directly
    // into the held output register.
    assign head     = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;
    assign overflow = ovf_q;

endmodule : tx_sync_fifo

// File: rtl/uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder
//   Byte buffer and launch controller in front of the UART TX frame FSM.
//   Ports:
//     clk, rst        clock, asynchronous active-low reset
//     wr_en, wr_data  host byte write
//     tx_enable       0 holds the queue (sampled only while idle)
//     ovf_clr         clears the overflow flag
//     tx_busy         busy flag from the TX frame FSM
//     tx_data_valid   1-cycle launch pulse
//     tx_p_data       byte under transmission, held until the next launch
//     full, empty     FIFO occupancy flags
//     level           FIFO occupancy 0..DEPTH
//     overflow        sticky dropped-write flag
//   Launch sequence: IDLE -> ISSUE (pulse) -> WAIT_BUSY -> WAIT_DONE -> IDLE.
//   Waiting for busy to rise and then fall guarantees a launched frame is
//   acknowledged before the next one can be issued.
// -----------------------------------------------------------------------------
module uart_tx_feeder
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = $clog2(DEPTH)   // derived, leave at default
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  tx_enable,
    input  logic                  ovf_clr,
    input  logic                  tx_busy,
    output logic                  tx_data_valid,
    output logic [DATA_WIDTH-1:0] tx_p_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_W:0]       level,
    output logic                  overflow
);

    launch_state_e         state_q, state_d;
    logic                  tx_data_valid_q, tx_data_valid_d;
    logic [DATA_WIDTH-1:0] tx_p_data_q, tx_p_data_d;

    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_empty;

    tx_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (fifo_pop),
        .ovf_clr  (ovf_clr),
        .head     (fifo_head),
        .full     (full),
        .empty    (fifo_empty),
        .level    (level),
        .overflow (overflow)
    );

    always_comb begin
        state_d         = state_q;
        tx_data_valid_d = 1'b0;
        tx_p_data_d     = tx_p_data_q;
        fifo_pop        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // The pop and the capture of the head happen on the same edge,
                // so the pulse and its data appear together.
                if (launch_ok(fifo_empty, tx_enable, tx_busy)) begin
                    state_d         = ST_ISSUE;
                    tx_data_valid_d = 1'b1;
                    tx_p_data_d     = fifo_head;
                    fifo_pop        = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            tx_data_valid_q <= 1'b0;
            tx_p_data_q     <= '0;
        end else begin
            state_q         <= state_d;
            tx_data_valid_q <= tx_data_valid_d;
            tx_p_data_q     <= tx_p_data_d;
        end
    end

    assign tx_data_valid = tx_data_valid_q;
    assign tx_p_data     = tx_p_data_q;
    assign empty         = fifo_empty;

endmodule : uart_tx_feeder
